// File: rtl/serial_link_pwr_seq.sv
// serial_link_pwr_seq: per-link power sequencer (clock ungate -> reset release -> de-isolate, and reverse).
// Latency: power-up min 2+ClkSettleCycles+RstCycles cycles, power-down 2+RstCycles cycles; outputs Moore from state.
// Backpressure: none; requests outside their legal state are dropped, isolate handshakes time out into ERROR.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   up_req_i, down_req_i    : per-link single-cycle power-up / power-down requests
//   err_clr_i               : per-link clear of the ERROR state
//   isolated_i              : per-link {out, in} isolated status from the AXI isolators
//   isolate_o               : per-link {out, in} isolate requests
//   clk_ena_o, reset_no     : per-link clock gate enable and active-low link reset
//   state_o, err_o          : per-link state encoding and error flag
//   busy_o                  : any link in a transitional state
module serial_link_pwr_seq #(
  parameter int unsigned NumLinks        = 2,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned RstCycles       = 8,
  parameter int unsigned TimeoutCycles   = 1024,
  parameter int unsigned CntWidth        = $clog2(
    ((ClkSettleCycles > RstCycles ? ClkSettleCycles : RstCycles) > TimeoutCycles ?
     (ClkSettleCycles > RstCycles ? ClkSettleCycles : RstCycles) : TimeoutCycles) + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumLinks-1:0]      up_req_i,
  input  logic [NumLinks-1:0]      down_req_i,
  input  logic [NumLinks-1:0]      err_clr_i,
  input  logic [NumLinks-1:0][1:0] isolated_i,
  output logic [NumLinks-1:0][1:0] isolate_o,
  output logic [NumLinks-1:0]      clk_ena_o,
  output logic [NumLinks-1:0]      reset_no,
  output logic [NumLinks-1:0][2:0] state_o,
  output logic [NumLinks-1:0]      err_o,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    CLK_ON     = 3'd1,
    RST_HOLD   = 3'd2,
    DEISO      = 3'd3,
    ACTIVE     = 3'd4,
    ISO        = 3'd5,
    RST_ASSERT = 3'd6,
    ERROR      = 3'd7
  } state_e;

  // Counter reload values: a phase lasting N cycles loads N-1 and exits on zero.
  localparam logic [CntWidth-1:0] ClkLoad = CntWidth'(ClkSettleCycles - 1);
  localparam logic [CntWidth-1:0] RstLoad = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] ToLoad  = CntWidth'(TimeoutCycles - 1);

  logic [NumLinks-1:0] busy_vec;

  for (genvar g = 0; g < NumLinks; g++) begin : g_link
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_dec;
    logic                cnt_zero;
    logic [1:0]          iso;
    logic                clk_en, rst_n, err, busy;

    assign cnt_zero = (cnt_q == '0);
    // Saturating decrement: the counter never wraps below zero.
    assign cnt_dec  = cnt_zero ? '0 : cnt_q - 1'b1;

    // State register
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= OFF;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state and counter logic
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        OFF: begin
          if (up_req_i[g]) begin
            state_d = CLK_ON;
            cnt_d   = ClkLoad;
          end
        end
        CLK_ON: begin
          cnt_d = cnt_dec;
          if (cnt_zero) begin
            state_d = RST_HOLD;
            cnt_d   = RstLoad;
          end
        end
        RST_HOLD: begin
          cnt_d = cnt_dec;
          if (cnt_zero) begin
            state_d = DEISO;
            cnt_d   = ToLoad;
          end
        end
        DEISO: begin
          cnt_d = cnt_dec;
          // Handshake match wins over a timeout expiring in the same cycle.
          if (isolated_i[g] == 2'b00) state_d = ACTIVE;
          else if (cnt_zero)          state_d = ERROR;
        end
        ACTIVE: begin
          if (down_req_i[g]) begin
            state_d = ISO;
            cnt_d   = ToLoad;
          end
        end
        ISO: begin
          cnt_d = cnt_dec;
          if (isolated_i[g] == 2'b11) begin
            state_d = RST_ASSERT;
            cnt_d   = RstLoad;
          end else if (cnt_zero) begin
            state_d = ERROR;
          end
        end
        RST_ASSERT: begin
          cnt_d = cnt_dec;
          if (cnt_zero) state_d = OFF;
        end
        ERROR: begin
          if (err_clr_i[g]) state_d = OFF;
        end
        default: state_d = OFF;
      endcase
    end

    // Moore output decode
    always_comb begin
      iso    = 2'b11;
      clk_en = 1'b0;
      rst_n  = 1'b0;
      err    = 1'b0;
      busy   = 1'b0;
      case (state_q)
        OFF:        ;
        CLK_ON:     begin clk_en = 1'b1; busy = 1'b1; end
        RST_HOLD:   begin clk_en = 1'b1; busy = 1'b1; end
        DEISO:      begin iso = 2'b00; clk_en = 1'b1; rst_n = 1'b1; busy = 1'b1; end
        ACTIVE:     begin iso = 2'b00; clk_en = 1'b1; rst_n = 1'b1; end
        ISO:        begin clk_en = 1'b1; rst_n = 1'b1; busy = 1'b1; end
        RST_ASSERT: begin clk_en = 1'b1; busy = 1'b1; end
        ERROR:      err = 1'b1;
        default:    ;
      endcase
    end

    assign isolate_o[g] = iso;
    assign clk_ena_o[g] = clk_en;
    assign reset_no[g]  = rst_n;
    assign err_o[g]     = err;
    assign state_o[g]   = state_q;
    assign busy_vec[g]  = busy;
  end

  assign busy_o = |busy_vec;

endmodule
